// File: rtl/dmem_if.sv
// dmem_if: valid/ready load/store request and response channel between the core's LSU and the data memory
//   master : initiator (drives req_valid/req_write/req_addr/req_size/req_wdata and rsp_ready)
//   slave  : responder (drives req_ready and rsp_valid/rsp_rdata/rsp_err)
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [2:0]  req_size;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   modport master (
      output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data RAM responder with wait states, funct3-sized accesses and load extension
//   clk   : clock, all state on rising edge
//   rst   : asynchronous active-high reset
//   bus   : dmem_if.slave request/response channel
//   load_count / store_count : accepted good load/store responses (only with DMEM_STATS_EN defined)
module dmem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input logic   clk,
   input logic   rst,
   dmem_if.slave bus
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0] load_count,
   output logic [31:0] store_count
`endif
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam int WORDS = 1 << ADDR_WIDTH;
   localparam bit LIVE = (WAIT_CYCLES == 0);
   localparam logic [3:0] LAST = LIVE ? 4'd0 : 4'(WAIT_CYCLES - 1);
   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        req_ready_q, rsp_valid_q, rsp_err_q;
   logic [31:0] rsp_rdata_q;
   logic        wr_q;
   logic [31:0] addr_q, wdata_q;
   logic [2:0]  size_q;
   logic [31:0] mem_q [WORDS];
   logic        a_wr, acc, err_d, we;
   logic [31:0] a_addr, a_wdata, rd_word, ld_val, rsp_rdata_d, wd_al;
   logic [2:0]  sz;
   logic [1:0]  lane;
   logic [ADDR_WIDTH-1:0] idx;
   logic [7:0]  b_v;
   logic [15:0] h_v;
   logic [3:0]  be;
   // With no wait states the access happens on the accept edge, so it must use the live request.
   assign a_wr    = LIVE ? bus.req_write : wr_q;
   assign a_addr  = LIVE ? bus.req_addr  : addr_q;
   assign sz      = LIVE ? bus.req_size  : size_q;
   assign a_wdata = LIVE ? bus.req_wdata : wdata_q;
   assign acc = LIVE ? (state_q == IDLE && bus.req_valid) : (state_q == WAIT && cnt_q == LAST);
   assign lane = a_addr[1:0];
   assign idx  = a_addr[ADDR_WIDTH+1:2];
   // 011/11x are not loads or stores; BU/HU only exist as loads.
   assign err_d = sz == 3'b011 || sz[2:1] == 2'b11 || (sz[2] && a_wr)
                  || (sz[1:0] == 2'b01 && a_addr[0])
                  || (sz[1:0] == 2'b10 && lane != 2'b00)
                  || (|a_addr[31:ADDR_WIDTH+2]);
   assign rd_word = mem_q[idx];
   assign b_v = rd_word[{lane, 3'b000} +: 8];
   assign h_v = lane[1] ? rd_word[31:16] : rd_word[15:0];
   assign ld_val = sz[1:0] == 2'b00 ? {{24{~sz[2] & b_v[7]}}, b_v}
                 : sz[1:0] == 2'b01 ? {{16{~sz[2] & h_v[15]}}, h_v}
                 : rd_word;
   assign rsp_rdata_d = (err_d || a_wr) ? 32'd0 : ld_val;
   // Replicate store data so the enabled lanes pick up the right bytes.
   assign wd_al = sz[1:0] == 2'b00 ? {4{a_wdata[7:0]}}
                : sz[1:0] == 2'b01 ? {2{a_wdata[15:0]}}
                : a_wdata;
   assign be = sz[1:0] == 2'b00 ? 4'b0001 << lane
             : sz[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011)
             : 4'b1111;
   assign we = acc && a_wr && !err_d;
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (we && be[i]) mem_q[idx][8*i +: 8] <= wd_al[8*i +: 8];
   end
`ifdef DMEM_STATS_EN
   logic [31:0] load_cnt_q, store_cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_cnt_q  <= '0;
         store_cnt_q <= '0;
      end else if (rsp_valid_q && bus.rsp_ready && !rsp_err_q) begin
         load_cnt_q  <= load_cnt_q + {31'd0, !wr_q};
         store_cnt_q <= store_cnt_q + {31'd0, wr_q};
      end
   end
   assign load_count  = load_cnt_q;
   assign store_count = store_cnt_q;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         size_q      <= '0;
         wdata_q     <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.req_valid) begin
               wr_q        <= bus.req_write;
               addr_q      <= bus.req_addr;
               size_q      <= bus.req_size;
               wdata_q     <= bus.req_wdata;
               cnt_q       <= '0;
               req_ready_q <= 1'b0;
               state_q     <= LIVE ? RESP : WAIT;
               if (LIVE) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rsp_rdata_d;
                  rsp_err_q   <= err_d;
               end
            end
            WAIT: if (cnt_q == LAST) begin
               state_q     <= RESP;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= rsp_rdata_d;
               rsp_err_q   <= err_d;
            end else begin
               cnt_q <= cnt_q + 4'd1;
            end
            RESP: if (bus.rsp_ready) begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (ADDR_WIDTH=8, WAIT_CYCLES=2)
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   dmem_if bus ();
`ifdef DMEM_STATS_EN
   logic [31:0] load_count, store_count;
`endif
   dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
`ifdef DMEM_STATS_EN
      ,
      .load_count(load_count),
      .store_count(store_count)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask
   task automatic xact(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_size  = s;
      bus.req_wdata = d;
      @(posedge clk);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         lat++;
         if (bus.rsp_valid) break;
      end
      if (!bus.rsp_valid) lat = -1;
      rd = bus.rsp_rdata;
      e  = bus.rsp_err;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask
   task automatic run(input string tag, input logic w, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_e);
      logic [31:0] rd;
      logic e;
      int lat;
      xact(w, a, s, d, rd, e, lat);
      check({tag, " rdata"}, rd, exp_rd);
      check({tag, " err"}, {31'd0, e}, {31'd0, exp_e});
      check({tag, " latency"}, 32'(lat), 32'd3);
      check({tag, " idle ready"}, {31'd0, bus.req_ready}, 32'd1);
   endtask
   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_size  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      #12;
      check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
      check("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run("SW 0x10", 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
      run("LW 0x10", 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);
      run("LB 0x13", 1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0);
      run("LBU 0x13", 1'b0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 1'b0);
      run("LH 0x12", 1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0);
      run("LHU 0x10", 1'b0, 32'h10, 3'b101, 32'h0, 32'h0000BEEF, 1'b0);
      run("LB 0x10", 1'b0, 32'h10, 3'b000, 32'h0, 32'hFFFFFFEF, 1'b0);
      run("SB 0x11", 1'b1, 32'h11, 3'b000, 32'hFFFFFF55, 32'h0, 1'b0);
      run("LW after SB", 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 1'b0);
      run("SH 0x12", 1'b1, 32'h12, 3'b001, 32'hFFFF1234, 32'h0, 1'b0);
      run("LW after SH", 1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0);
      run("LW 0x402 misaligned", 1'b0, 32'h402, 3'b010, 32'h0, 32'h0, 1'b1);
      run("LH 0x11 misaligned", 1'b0, 32'h11, 3'b001, 32'h0, 32'h0, 1'b1);
      run("SW 0x0", 1'b1, 32'h0, 3'b010, 32'h11223344, 32'h0, 1'b0);
      run("SW 0x400 out of range", 1'b1, 32'h400, 3'b010, 32'hCAFEF00D, 32'h0, 1'b1);
      run("LW 0x0 unchanged", 1'b0, 32'h0, 3'b010, 32'h0, 32'h11223344, 1'b0);
      run("size 011", 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
      run("store size 100", 1'b1, 32'h10, 3'b100, 32'h77, 32'h0, 1'b1);
      run("LW after bad store", 1'b0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 1'b0);
      run("SW 0x14", 1'b1, 32'h14, 3'b010, 32'h0BADF00D, 32'h0, 1'b0);
      begin : backpressure
         int lat;
         @(negedge clk);
         bus.req_valid = 1'b1;
         bus.req_write = 1'b0;
         bus.req_addr  = 32'h10;
         bus.req_size  = 3'b010;
         @(posedge clk);
         lat = 0;
         while (lat < 20) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            lat++;
            if (bus.rsp_valid) break;
         end
         check("bp latency", 32'(lat), 32'd3);
         bus.req_valid = 1'b1;
         bus.req_write = 1'b1;
         bus.req_addr  = 32'h14;
         bus.req_wdata = 32'h99;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp rdata", bus.rsp_rdata, 32'h123455EF);
            check("bp err", {31'd0, bus.rsp_err}, 32'd0);
            check("bp req_ready", {31'd0, bus.req_ready}, 32'd0);
         end
         bus.req_valid = 1'b0;
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         bus.rsp_ready = 1'b0;
         check("bp released rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
         check("bp released req_ready", {31'd0, bus.req_ready}, 32'd1);
      end
      run("LW 0x14 untouched", 1'b0, 32'h14, 3'b010, 32'h0, 32'h0BADF00D, 1'b0);
      run("SW 0x20 prior", 1'b1, 32'h20, 3'b010, 32'h5A5A0000, 32'h0, 1'b0);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h20;
      bus.req_size  = 3'b010;
      bus.req_wdata = 32'hA5A5A5A5;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
`ifdef DMEM_STATS_EN
      check("rst load_count", load_count, 32'd0);
      check("rst store_count", store_count, 32'd0);
`endif
      repeat (4) @(negedge clk);
      check("rst no late rsp", {31'd0, bus.rsp_valid}, 32'd0);
      run("LW 0x20 prior", 1'b0, 32'h20, 3'b010, 32'h0, 32'h5A5A0000, 1'b0);
`ifdef DMEM_STATS_EN
      check("stats load_count", load_count, 32'd1);
      check("stats store_count", store_count, 32'd0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
